timer_ctrl_fsm: RTL and testbench

Control stage that sits directly in front of the BCD down-counter chain (mod-10/mod-6 digit counters) of the cooking timer. It generates the chain's enable tick, load and clear strobes, and consumes the chain's all-zero flag to end a cook cycle. It also drives the heater-on and end-of-cycle alarm outputs.

---
 rtl/timer_ctrl_fsm.sv | 137 +++++++++++++
 tb/tb_timer_ctrl_fsm.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl_fsm.sv
// Cooking-timer control FSM: drives the BCD down-counter chain (tick, load, clear),
// the heater and the end-of-cycle alarm, and ends a cook cycle on the chain's all-zero flag.
module timer_ctrl_fsm #(
   parameter int TICK_DIV     = 50000000,
   parameter int ALARM_CYCLES = 150000000
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       start,
   input  logic       stop,
   input  logic       door_closed,
   input  logic       load_req,
   input  logic       zero_all,
   output logic       cnt_en,
   output logic       cnt_loadn,
   output logic       cnt_clrn,
   output logic       heater_on,
   output logic       alarm,
   output logic [2:0] state
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int AW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
   localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
   localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_RUN   = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   // Kept as a plain vector so the unused codes 5-7 are representable and recoverable.
   logic [2:0]    state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [AW-1:0] acnt_q,  acnt_d;
   logic          cnt_en_q,    cnt_en_d;
   logic          cnt_loadn_q, cnt_loadn_d;
   logic          cnt_clrn_q,  cnt_clrn_d;
   logic          heater_q,    heater_d;
   logic          alarm_q,     alarm_d;

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= S_IDLE;
         presc_q     <= '0;
         acnt_q      <= '0;
         cnt_en_q    <= 1'b0;
         cnt_loadn_q <= 1'b1;
         cnt_clrn_q  <= 1'b0;
         heater_q    <= 1'b0;
         alarm_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         acnt_q      <= acnt_d;
         cnt_en_q    <= cnt_en_d;
         cnt_loadn_q <= cnt_loadn_d;
         cnt_clrn_q  <= cnt_clrn_d;
         heater_q    <= heater_d;
         alarm_q     <= alarm_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      presc_d    = presc_q;
      acnt_d     = acnt_q;
      cnt_en_d   = 1'b0;
      cnt_clrn_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (stop) begin
               cnt_clrn_d = 1'b0;
            end else if (load_req) begin
               state_d = S_LOAD;
            end else if (start && door_closed && !zero_all) begin
               state_d = S_RUN;
               presc_d = '0;
            end
         end

         S_LOAD: state_d = S_IDLE;

         S_RUN: begin
            if (!door_closed || stop) begin
               state_d = S_PAUSE;
            end else if (zero_all) begin
               state_d = S_DONE;
               acnt_d  = '0;
            end else if (presc_q == TICK_LAST) begin
               // Tick lands in the next cycle; zero_all is already low here so the chain cannot wrap.
               presc_d  = '0;
               cnt_en_d = 1'b1;
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end

         S_PAUSE: begin
            if (stop) begin
               cnt_clrn_d = 1'b0;
               presc_d    = '0;
               state_d    = S_IDLE;
            end else if (start && door_closed) begin
               state_d = S_RUN;
            end
         end

         S_DONE: begin
            if (stop || !door_closed || (acnt_q == ALARM_LAST)) begin
               state_d = S_IDLE;
            end else begin
               acnt_d = acnt_q + 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase

      // Level outputs follow the state being entered, so they line up with the registered state code.
      cnt_loadn_d = (state_d != S_LOAD);
      heater_d    = (state_d == S_RUN);
      alarm_d     = (state_d == S_DONE);
   end

   assign cnt_en    = cnt_en_q;
   assign cnt_loadn = cnt_loadn_q;
   assign cnt_clrn  = cnt_clrn_q;
   assign heater_on = heater_q;
   assign alarm     = alarm_q;
   assign state     = state_q;

endmodule

// File: tb/tb_timer_ctrl_fsm.sv
// Scoreboard bench for timer_ctrl_fsm with a behavioural BCD chain model supplying zero_all.
module tb_timer_ctrl_fsm;

   logic       clk = 1'b0;
   logic       clr, start, stop, door_closed, load_req, zero_all;
   logic       cnt_en, cnt_loadn, cnt_clrn, heater_on, alarm;
   logic [2:0] state;

   localparam logic [2:0] I = 3'd0, L = 3'd1, R = 3'd2, P = 3'd3, D = 3'd4;

   timer_ctrl_fsm #(.TICK_DIV(4), .ALARM_CYCLES(3)) dut (
      .clk(clk), .clr(clr), .start(start), .stop(stop), .door_closed(door_closed),
      .load_req(load_req), .zero_all(zero_all), .cnt_en(cnt_en), .cnt_loadn(cnt_loadn),
      .cnt_clrn(cnt_clrn), .heater_on(heater_on), .alarm(alarm), .state(state)
   );

   always #5 clk = ~clk;

   // Chain model: clear beats load beats decrement.
   logic [3:0] chain_q  = 4'd0;
   logic [3:0] chain_ld = 4'd2;
   always @(posedge clk) begin
      if (!cnt_clrn)                    chain_q <= 4'd0;
      else if (!cnt_loadn)              chain_q <= chain_ld;
      else if (cnt_en && chain_q != 0)  chain_q <= chain_q - 4'd1;
   end
   assign zero_all = (chain_q == 4'd0);

   typedef struct {
      string      name;
      logic [2:0] st;
      logic       en, ldn, crn, ht, al;
   } exp_t;
   exp_t sb_q[$];

   int n_chk  = 0;
   int n_fail = 0;
   bit armed  = 1'b0;

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (armed) begin
         n_chk++;
         if ((cnt_en && zero_all) || (cnt_en && state != R) ||
             (heater_on && state != R) || (alarm && state != D)) begin
            n_fail++;
            $display("FAIL invariant: state=%0d cnt_en=%b zero_all=%b heater=%b alarm=%b",
                     state, cnt_en, zero_all, heater_on, alarm);
         end
      end
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         n_chk++;
         armed = 1'b1;
         if ({state, cnt_en, cnt_loadn, cnt_clrn, heater_on, alarm} !==
             {e.st, e.en, e.ldn, e.crn, e.ht, e.al}) begin
            n_fail++;
            $display("FAIL %s: got state=%0d en=%b loadn=%b clrn=%b heater=%b alarm=%b, expected state=%0d en=%b loadn=%b clrn=%b heater=%b alarm=%b",
                     e.name, state, cnt_en, cnt_loadn, cnt_clrn, heater_on, alarm,
                     e.st, e.en, e.ldn, e.crn, e.ht, e.al);
         end
      end
   end

   // Apply inputs for one cycle and queue the outputs expected after the following edge.
   task automatic step(input string nm, input logic c, s, p, d, l,
                       input logic [2:0] es, input logic een, eldn, ecrn, eht, eal);
      exp_t e;
      @(negedge clk);
      clr = c; start = s; stop = p; door_closed = d; load_req = l;
      e.name = nm; e.st = es; e.en = een; e.ldn = eldn; e.crn = ecrn; e.ht = eht; e.al = eal;
      sb_q.push_back(e);
   endtask

   task automatic idle_step(input string nm);
      step(nm, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, I, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic load_chain(input logic [3:0] v);
      chain_ld = v;
      step("load", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, L, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step("load_exit", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, I, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic run_start(input string nm);
      step(nm, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, R, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, queue=%0d expected 0", sb_q.size());
      $fatal(1);
   end

   initial begin
      clr = 1'b1; start = 1'b0; stop = 1'b0; door_closed = 1'b1; load_req = 1'b0;

      for (int i = 0; i < 3; i++)
         step("reset", 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              I, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_step("reset_release");

      // Chain reads 00:00 after reset, so start is ignored.
      step("start_zero_all", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, I, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      load_chain(4'd2);
      step("start_door_open", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, I, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

      // Normal run: ticks at RUN-cycles 4 and 8, DONE for 3 cycles, then IDLE.
      run_start("run_start");
      for (int k = 1; k <= 13; k++)
         step("normal_run", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
              (k <= 9) ? R : ((k <= 12) ? D : I),
              (k == 4 || k == 8), 1'b1, 1'b1, (k <= 9), (k >= 10 && k <= 12));

      // Door opens at prescaler 2; resume finishes the partial second.
      load_chain(4'd2);
      run_start("run2_start");
      step("run2_c1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, R, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      step("run2_c2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, R, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      step("door_open", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step("pause_hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, P, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      run_start("resume");
      step("resume_c1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, R, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      step("resume_tick", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, R, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step("resume_c3", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, R, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

      // Cancel: stop pauses, second stop clears and returns to IDLE.
      step("stop_run", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, P, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step("pause_wait", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, P, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step("cancel", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, I, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_step("after_cancel");

      // start and stop together in IDLE with a loaded chain: stop wins.
      load_chain(4'd2);
      step("start_stop_idle", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, I, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_step("after_start_stop");

      // Short run into DONE; start ignored there, door opening ends the alarm early.
      load_chain(4'd1);
      run_start("run3_start");
      for (int k = 1; k <= 5; k++)
         step("run3", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, R, (k == 4), 1'b1, 1'b1, 1'b1, 1'b0);
      step("done_enter", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, D, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      step("done_start", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, D, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      step("done_door", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, I, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle_step("after_done");

      // clr in the middle of a run overrides everything.
      load_chain(4'd2);
      run_start("run4_start");
      step("run4_c1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, R, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      step("clr_in_run", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, I, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_step("clr_release");

      // Illegal state code recovers to IDLE on the next edge.
      @(negedge clk);
      force dut.state_q = 3'd6;
      #1 release dut.state_q;
      begin
         exp_t e;
         e.name = "illegal_state"; e.st = I; e.en = 1'b0; e.ldn = 1'b1;
         e.crn = 1'b1; e.ht = 1'b0; e.al = 1'b0;
         sb_q.push_back(e);
      end
      idle_step("after_illegal");

      repeat (3) @(posedge clk);
      #2;
      n_chk++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
